// File: rtl/pc_unit.sv
// Program-counter unit for the RV32I fetch stage.
// Next-PC select with trap/redirect/stall priority and a circular return-address stack.
module pc_unit #(
    parameter int unsigned      XLEN         = 32,
    parameter int unsigned      STEP         = 1,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic                           sysclk,
    input  logic                           sysreset,
    input  logic                           stall,
    input  logic                           redirect,
    input  logic [XLEN-1:0]                redirect_pc,
    input  logic                           trap,
    input  logic [XLEN-1:0]                trap_pc,
    input  logic                           ras_push,
    input  logic                           ras_pop,
    output logic [XLEN-1:0]                pc_curr,
    output logic [XLEN-1:0]                pc_next,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_empty,
    output logic                           ras_full
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH+1);

    logic [XLEN-1:0] entry [RAS_DEPTH];
    logic [PW-1:0]   sp;
    logic [PW-1:0]   top_idx;
    logic [XLEN-1:0] pc_d;
    logic            advance;
    logic            do_push;
    logic            do_pop;

    assign pc_next   = pc_curr + XLEN'(STEP);
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CW'(RAS_DEPTH));
    assign top_idx   = sp - 1'b1;

    assign advance = !stall && !trap && !redirect;
    assign do_push = advance && ras_push;
    assign do_pop  = advance && ras_pop && !ras_empty;

    always_comb begin
        pc_d = pc_next;
        if (trap)
            pc_d = trap_pc;
        else if (redirect)
            pc_d = redirect_pc;
        else if (stall)
            pc_d = pc_curr;
        else if (do_pop)
            pc_d = entry[top_idx];
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            pc_curr   <= RESET_VECTOR;
            sp        <= '0;
            ras_count <= '0;
        end else begin
            pc_curr <= pc_d;
            if (trap) begin
                sp        <= '0;
                ras_count <= '0;
            end else if (do_push && !do_pop) begin
                sp <= sp + 1'b1;
                if (!ras_full)
                    ras_count <= ras_count + 1'b1;
            end else if (do_pop && !do_push) begin
                sp        <= sp - 1'b1;
                ras_count <= ras_count - 1'b1;
            end
        end
    end

    // Push+pop on a non-empty stack replaces the top in place
    always_ff @(posedge sysclk) begin
        if (!sysreset && do_push) begin
            if (do_pop)
                entry[top_idx] <= pc_next;
            else
                entry[sp] <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: default 32-bit/STEP=1 instance
// plus an 8-bit/STEP=4 instance for wrap-around.
module tb_pc_unit;

    logic        sysclk = 1'b0;
    logic        sysreset, stall, redirect, trap, ras_push, ras_pop;
    logic [31:0] redirect_pc, trap_pc;
    logic [31:0] pc_curr, pc_next;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full;

    logic        b_reset;
    logic [7:0]  b_pc_curr, b_pc_next;
    logic [2:0]  b_count;
    logic        b_empty, b_full;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        bit          b;
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;

    exp_t sbq[$];

    always #5 sysclk = ~sysclk;

    pc_unit dut (
        .sysclk(sysclk), .sysreset(sysreset), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .trap(trap), .trap_pc(trap_pc),
        .ras_push(ras_push), .ras_pop(ras_pop),
        .pc_curr(pc_curr), .pc_next(pc_next), .ras_count(ras_count),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    pc_unit #(.XLEN(8), .STEP(4), .RESET_VECTOR(8'hF0), .RAS_DEPTH(4)) dut8 (
        .sysclk(sysclk), .sysreset(b_reset), .stall(1'b0),
        .redirect(1'b0), .redirect_pc(8'h00),
        .trap(1'b0), .trap_pc(8'h00),
        .ras_push(1'b0), .ras_pop(1'b0),
        .pc_curr(b_pc_curr), .pc_next(b_pc_next), .ras_count(b_count),
        .ras_empty(b_empty), .ras_full(b_full)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then compare every queued expectation
    task automatic drain();
        exp_t e;
        @(posedge sysclk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (!e.b) begin
                chk({e.tag, ".pc"},    pc_curr,          e.pc);
                chk({e.tag, ".pnx"},   pc_next,          e.pc + 32'd1);
                chk({e.tag, ".cnt"},   32'(ras_count),   e.cnt);
                chk({e.tag, ".empty"}, 32'(ras_empty),   32'(e.cnt == 0));
                chk({e.tag, ".full"},  32'(ras_full),    32'(e.cnt == 4));
            end else begin
                chk({e.tag, ".pc"},    32'(b_pc_curr),   e.pc);
                chk({e.tag, ".pnx"},   32'(b_pc_next),   (e.pc + 32'd4) & 32'hFF);
                chk({e.tag, ".cnt"},   32'(b_count),     e.cnt);
            end
        end
    endtask

    task automatic t(input string tag, input logic rst, st, rd,
                     input logic [31:0] rpc, input logic tr,
                     input logic [31:0] tpc, input logic pu, po,
                     input logic [31:0] epc, ecnt);
        exp_t e;
        sysreset    = rst;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        trap        = tr;
        trap_pc     = tpc;
        ras_push    = pu;
        ras_pop     = po;
        e.tag = tag; e.b = 1'b0; e.pc = epc; e.cnt = ecnt;
        sbq.push_back(e);
        drain();
    endtask

    task automatic tb8(input string tag, input logic rst, input logic [31:0] epc);
        exp_t e;
        b_reset = rst;
        e.tag = tag; e.b = 1'b1; e.pc = epc; e.cnt = 0;
        sbq.push_back(e);
        drain();
    endtask

    initial begin
        sysreset = 1'b1; stall = 1'b0; redirect = 1'b0; trap = 1'b0;
        ras_push = 1'b0; ras_pop = 1'b0;
        redirect_pc = '0; trap_pc = '0;
        b_reset = 1'b1;
        #1;

        t("rst",   1,0,0,0,      0,0,     0,0, 32'h0,   0);
        t("run1",  0,0,0,0,      0,0,     0,0, 32'h1,   0);
        t("run2",  0,0,0,0,      0,0,     0,0, 32'h2,   0);
        t("run3",  0,0,0,0,      0,0,     0,0, 32'h3,   0);

        t("rd10",  0,0,1,'h10,   0,0,     0,0, 32'h10,  0);
        t("push",  0,0,0,0,      0,0,     1,0, 32'h11,  1);
        t("rd40",  0,0,1,'h40,   0,0,     0,0, 32'h40,  1);
        t("s41",   0,0,0,0,      0,0,     0,0, 32'h41,  1);
        t("s42",   0,0,0,0,      0,0,     0,0, 32'h42,  1);
        t("pop42", 0,0,0,0,      0,0,     0,1, 32'h11,  0);

        t("rd100", 0,0,1,'h100,  0,0,     0,0, 32'h100, 0);
        t("pushA", 0,0,0,0,      0,0,     1,0, 32'h101, 1);
        t("pushB", 0,0,0,0,      0,0,     1,0, 32'h102, 2);
        t("pushC", 0,0,0,0,      0,0,     1,0, 32'h103, 3);
        t("pushD", 0,0,0,0,      0,0,     1,0, 32'h104, 4);
        t("pushE", 0,0,0,0,      0,0,     1,0, 32'h105, 4);
        t("pop1",  0,0,0,0,      0,0,     0,1, 32'h105, 3);
        t("pop2",  0,0,0,0,      0,0,     0,1, 32'h104, 2);
        t("pop3",  0,0,0,0,      0,0,     0,1, 32'h103, 1);
        t("pop4",  0,0,0,0,      0,0,     0,1, 32'h102, 0);
        t("pop5",  0,0,0,0,      0,0,     0,1, 32'h103, 0);

        t("push1", 0,0,0,0,      0,0,     1,0, 32'h104, 1);
        t("all3",  0,1,1,'h200,  1,'h100, 0,0, 32'h100, 0);
        t("strd",  0,1,1,'h200,  0,0,     0,0, 32'h200, 0);
        t("push2", 0,0,0,0,      0,0,     1,0, 32'h201, 1);
        t("stpop", 0,1,0,0,      0,0,     0,1, 32'h201, 1);
        t("stpp",  0,1,0,0,      0,0,     1,1, 32'h201, 1);
        t("rdpsh", 0,0,1,'h300,  0,0,     1,0, 32'h300, 1);

        t("trap",  0,0,0,0,      1,'h10,  0,0, 32'h10,  0);
        t("pu11",  0,0,0,0,      0,0,     1,0, 32'h11,  1);
        t("rd2f",  0,0,1,'h2F,   0,0,     0,0, 32'h2F,  1);
        t("pu30",  0,0,0,0,      0,0,     1,0, 32'h30,  2);
        t("rd50",  0,0,1,'h50,   0,0,     0,0, 32'h50,  2);
        t("pp2",   0,0,0,0,      0,0,     1,1, 32'h30,  2);
        t("pp2t",  0,0,0,0,      0,0,     0,1, 32'h51,  1);
        t("pp2b",  0,0,0,0,      0,0,     0,1, 32'h11,  0);
        t("rd50e", 0,0,1,'h50,   0,0,     0,0, 32'h50,  0);
        t("ppe",   0,0,0,0,      0,0,     1,1, 32'h51,  1);
        t("ppet",  0,0,0,0,      0,0,     0,1, 32'h51,  0);
        t("pope",  0,0,0,0,      0,0,     0,1, 32'h52,  0);

        t("pu53",  0,0,0,0,      0,0,     1,0, 32'h53,  1);
        t("rstst", 1,1,1,'h80,   0,0,     1,0, 32'h0,   0);
        t("post",  0,0,0,0,      0,0,     0,0, 32'h1,   0);

        tb8("b.rst", 1, 32'hF0);
        tb8("b.f4",  0, 32'hF4);
        tb8("b.f8",  0, 32'hF8);
        tb8("b.fc",  0, 32'hFC);
        tb8("b.wr",  0, 32'h00);
        tb8("b.04",  0, 32'h04);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RV32I core fetch stage; successor to the fixed 32-bit sequential/branch-select PC. Adds configurable width, step and reset vector, a fetch stall, a trap entry path with defined priority, and a small circular return-address stack (RAS). The RAS predicts return targets when decode flags a call or return. Sits between the control unit/execute branch resolution and instruction memory address input.

## Interface
- XLEN, 32, PC and address width in bits
- STEP, 1, sequential increment (1 = word-addressed instruction memory, 4 = byte-addressed)
- RESET_VECTOR, 0, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥ 2

- sysclk  in  1  system clock; all state updates on rising edge
- sysreset  in  1  synchronous, active-high reset
- stall  in  1  hold PC and RAS this cycle
- redirect  in  1  branch/jump resolution; load redirect_pc
- redirect_pc  in  XLEN  redirect target
- trap  in  1  exception/interrupt entry; load trap_pc, flush RAS
- trap_pc  in  XLEN  trap handler address
- ras_push  in  1  current instruction is a call; push pc_curr+STEP
- ras_pop  in  1  current instruction is a return; fetch from RAS top
- pc_curr  out  XLEN  registered current PC
- pc_next  out  XLEN  pc_curr + STEP (combinational, mod 2^XLEN)
- ras_count  out  clog2(RAS_DEPTH+1)  valid RAS entries
- ras_empty  out  1  ras_count == 0
- ras_full  out  1  ras_count == RAS_DEPTH

## Operation
- Next-PC priority, highest first: sysreset → RESET_VECTOR; trap → trap_pc; redirect → redirect_pc; stall → hold; ras_pop with ras_count>0 → RAS top; otherwise pc_curr+STEP.
- advance = !stall && !trap && !redirect && !sysreset. ras_push/ras_pop affect the RAS only when advance=1; otherwise they are ignored.
- Trap: ras_count←0, stack pointer←0; entry contents are don't-care. Redirect does not modify the RAS.
- RAS is circular: write pointer sp indexes the next free slot; top = entry[sp−1 mod RAS_DEPTH].
- Push only: entry[sp]←pc_curr+STEP; sp←sp+1 mod RAS_DEPTH; ras_count←min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten silently and ras_full stays 1.
- Pop only, count>0: PC←top; sp←sp−1; count←count−1.
- Pop only, empty: PC←pc_curr+STEP; RAS unchanged; no error flag.
- Push and pop together, count>0: PC←top; entry[sp−1]←pc_curr+STEP; sp and count unchanged.
- Push and pop together, empty: PC←pc_curr+STEP; push performed; count←1.
- All arithmetic is unsigned mod 2^XLEN. PC wrap-around from 2^XLEN−STEP to 0 is legal and not flagged.

## Timing
- Single clock domain; all state registered. pc_curr updates one cycle after the qualifying input is sampled.
- Reset values: pc_curr=RESET_VECTOR, pc_next=RESET_VECTOR+STEP, ras_count=0, ras_empty=1, ras_full=0, sp=0.
- sysreset asserted mid-sequence overrides every other input that cycle; the RAS is cleared.
- Latency: redirect, trap and pop take effect on pc_curr at the next edge (1 cycle). pc_next follows pc_curr combinationally, with 0 cycles added.
- RAS top read is combinational from current state. A push in cycle N is poppable in cycle N+1.
- Stall for k cycles holds pc_curr, sp and ras_count constant for k edges.

## Test plan
- Reset then 3 free-running cycles (STEP=1, RESET_VECTOR=0) -> pc_curr 0,1,2,3; pc_next 1,2,3,4; ras_empty=1.
- At pc_curr=0x10, assert ras_push with redirect low; next cycle drive redirect_pc=0x40 with redirect high; later at 0x42 assert ras_pop -> pc_curr sequence 0x11, 0x40, …, 0x42, 0x11; ras_count 1 then 0. Because redirect blocks the RAS op in its cycle, the push is issued in a non-redirect cycle.
- Push 5 times at distinct PCs A..E with RAS_DEPTH=4, then pop 5 times -> pops return E, D, C, B; the fifth pop falls through to pc_curr+STEP; ras_full=1 after the 4th push and stays 1 on the 5th.
- With stall, trap and redirect asserted together (trap_pc=0x100, redirect_pc=0x200) -> pc_curr=0x100 and ras_count=0. With stall and redirect only -> pc_curr=0x200.
- ras_push and ras_pop together with count=2, top=0x30, pc_curr=0x50 -> pc_curr=0x30, new top=0x51, count=2. Same stimulus with the RAS empty -> pc_curr=0x51, count=1.
- XLEN=8, STEP=4, pc_curr=0xFC -> pc_next=0x00 and pc_curr wraps to 0x00. sysreset during a stalled cycle -> RESET_VECTOR.
